// File: rtl/sensor_ascii_pkg.sv
// Shared definitions for the sensor ASCII line sender: FSM states,
// character constants, line lengths and a digit-to-ASCII helper.
package sensor_ascii_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_SEND    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_EQ   = 8'h3D;
   localparam logic [7:0] ASCII_PCT  = 8'h25;
   localparam logic [7:0] ASCII_SP   = 8'h20;
   localparam logic [7:0] ASCII_C    = 8'h43;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   // Line lengths for CR+LF and LF-only terminations, and the matching
   // index of the final character.
   localparam logic [4:0] LINE_LEN_CRLF = 5'd15;
   localparam logic [4:0] LINE_LEN_LF   = 5'd14;
   localparam logic [3:0] LAST_IDX_CRLF = 4'd14;
   localparam logic [3:0] LAST_IDX_LF   = 4'd13;

   // Map one BCD digit onto its ASCII character.
   function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
      return ASCII_ZERO + {4'b0000, d};
   endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Combinational 8-bit binary to 3-digit BCD converter (double-dabble).
module bin2bcd8
   import sensor_ascii_pkg::*;
(
   input  logic [7:0] i_bin,
   output logic [3:0] o_hund,
   output logic [3:0] o_tens,
   output logic [3:0] o_ones
);

   logic [11:0] w_bcd;

   // Shift the binary value in MSB first, adding 3 to any digit >= 5 before each shift.
   always_comb begin
      w_bcd = 12'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_bcd[3:0] >= 4'd5) begin
            w_bcd[3:0] = w_bcd[3:0] + 4'd3;
         end else begin
            w_bcd[3:0] = w_bcd[3:0];
         end
         if (w_bcd[7:4] >= 4'd5) begin
            w_bcd[7:4] = w_bcd[7:4] + 4'd3;
         end else begin
            w_bcd[7:4] = w_bcd[7:4];
         end
         if (w_bcd[11:8] >= 4'd5) begin
            w_bcd[11:8] = w_bcd[11:8] + 4'd3;
         end else begin
            w_bcd[11:8] = w_bcd[11:8];
         end
         w_bcd = {w_bcd[10:0], i_bin[i]};
      end
   end

   assign o_hund = w_bcd[11:8];
   assign o_tens = w_bcd[7:4];
   assign o_ones = w_bcd[3:0];

endmodule

// File: rtl/sensor_ascii_sender.sv
// Formats one humidity/temperature reading as an ASCII line and pushes it
// into a UART TX FIFO one character per cycle, honouring the FIFO full flag.
// Build option: define SENSOR_SENDER_CRLF_EN to end the line with CR+LF
// (15 characters); otherwise the line ends with LF only (14 characters).
module sensor_ascii_sender
   import sensor_ascii_pkg::*;
#(
   parameter logic [7:0] HUM_TAG = 8'h48,
   parameter logic [7:0] TMP_TAG = 8'h54
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] humidity,
   input  logic [7:0] temperature,
   input  logic       full,
   output logic       push,
   output logic [7:0] ascii,
   output logic       busy,
   output logic       done
);

`ifdef SENSOR_SENDER_CRLF_EN
   localparam logic [3:0] LAST_IDX = LAST_IDX_CRLF;
`else
   localparam logic [3:0] LAST_IDX = LAST_IDX_LF;
`endif

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_hum_snap;
   logic [7:0] r_tmp_snap;
   logic [3:0] r_h2, r_h1, r_h0;
   logic [3:0] r_t2, r_t1, r_t0;
   logic [3:0] r_idx;
   logic       r_busy;
   logic       r_done;
   logic [3:0] w_h2, w_h1, w_h0;
   logic [3:0] w_t2, w_t1, w_t0;
   logic       w_push;
   logic [7:0] w_char;

   bin2bcd8 u_bcd_hum (
      .i_bin  (r_hum_snap),
      .o_hund (w_h2),
      .o_tens (w_h1),
      .o_ones (w_h0)
   );

   bin2bcd8 u_bcd_tmp (
      .i_bin  (r_tmp_snap),
      .o_hund (w_t2),
      .o_tens (w_t1),
      .o_ones (w_t0)
   );

   // A character leaves only in SEND and only when the FIFO has room this very cycle.
   assign w_push = (r_state == ST_SEND) && !full;

   // Next-state decode; SEND exits on the edge that writes the last character.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_CONVERT;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_CONVERT: begin
            w_state_next = ST_SEND;
         end
         ST_SEND: begin
            if (w_push && (r_idx == LAST_IDX)) begin
               w_state_next = ST_DONE;
            end else begin
               w_state_next = ST_SEND;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register plus busy/done flags registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next != ST_IDLE);
         r_done  <= (w_state_next == ST_DONE);
      end
   end

   // Snapshot the readings on start, latch BCD digits in CONVERT, advance the index per push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hum_snap <= 8'd0;
         r_tmp_snap <= 8'd0;
         r_h2       <= 4'd0;
         r_h1       <= 4'd0;
         r_h0       <= 4'd0;
         r_t2       <= 4'd0;
         r_t1       <= 4'd0;
         r_t0       <= 4'd0;
         r_idx      <= 4'd0;
      end else begin
         if ((r_state == ST_IDLE) && start) begin
            r_hum_snap <= humidity;
            r_tmp_snap <= temperature;
         end
         if (r_state == ST_CONVERT) begin
            r_h2  <= w_h2;
            r_h1  <= w_h1;
            r_h0  <= w_h0;
            r_t2  <= w_t2;
            r_t1  <= w_t1;
            r_t0  <= w_t0;
            r_idx <= 4'd0;
         end else if (w_push) begin
            r_idx <= r_idx + 4'd1;
         end
      end
   end

   // Character selected by the current index within the fixed line layout.
   always_comb begin
      w_char = 8'h00;
      case (r_idx)
         4'd0:  w_char = HUM_TAG;
         4'd1:  w_char = ASCII_EQ;
         4'd2:  w_char = digit_to_ascii(r_h2);
         4'd3:  w_char = digit_to_ascii(r_h1);
         4'd4:  w_char = digit_to_ascii(r_h0);
         4'd5:  w_char = ASCII_PCT;
         4'd6:  w_char = ASCII_SP;
         4'd7:  w_char = TMP_TAG;
         4'd8:  w_char = ASCII_EQ;
         4'd9:  w_char = digit_to_ascii(r_t2);
         4'd10: w_char = digit_to_ascii(r_t1);
         4'd11: w_char = digit_to_ascii(r_t0);
         4'd12: w_char = ASCII_C;
`ifdef SENSOR_SENDER_CRLF_EN
         4'd13: w_char = ASCII_CR;
         4'd14: w_char = ASCII_LF;
`else
         4'd13: w_char = ASCII_LF;
`endif
         default: w_char = 8'h00;
      endcase
   end

   // Output data is forced to zero whenever no character is being pushed.
   always_comb begin
      ascii = 8'h00;
      if (w_push) begin
         ascii = w_char;
      end else begin
         ascii = 8'h00;
      end
   end

   assign push = w_push;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_sensor_ascii_sender.sv
// Self-checking bench for sensor_ascii_sender: expected lines are built
// from the readings with decimal arithmetic and compared cycle by cycle.
module tb_sensor_ascii_sender;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] humidity;
   logic [7:0] temperature;
   logic       full;
   logic       push;
   logic [7:0] ascii;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];

   sensor_ascii_sender dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .humidity    (humidity),
      .temperature (temperature),
      .full        (full),
      .push        (push),
      .ascii       (ascii),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference line: tag, '=', three decimal digits, '%', ' ', tag, '=', digits, 'C', terminator.
   function automatic void build_line(input int h, input int t);
      exp_q.delete();
      exp_q.push_back(8'h48);
      exp_q.push_back(8'h3D);
      exp_q.push_back(8'(48 + h / 100));
      exp_q.push_back(8'(48 + (h / 10) % 10));
      exp_q.push_back(8'(48 + h % 10));
      exp_q.push_back(8'h25);
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h54);
      exp_q.push_back(8'h3D);
      exp_q.push_back(8'(48 + t / 100));
      exp_q.push_back(8'(48 + (t / 10) % 10));
      exp_q.push_back(8'(48 + t % 10));
      exp_q.push_back(8'h43);
`ifdef SENSOR_SENDER_CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
   endfunction

   // Send one line; optional forced stall, mid-line start/data poke, or mid-line reset.
   task automatic run_line(input logic [7:0] h, input logic [7:0] t,
                           input int stall_at, input int stall_len,
                           input int poke_at, input int rst_at, input bit rand_full);
      int k;
      int stall_rem;
      int cyc;
      bit f;
      build_line(int'(h), int'(t));
      k = 0;
      stall_rem = stall_len;
      cyc = 0;
      @(negedge clk);
      humidity = h;
      temperature = t;
      start = 1'b1;
      full = 1'b0;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("convert_busy", 32'(busy), 32'd1);
      check("convert_push", 32'(push), 32'd0);
      while (k < exp_q.size()) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (cyc > 200) begin
            check("send_timeout", 32'(k), 32'(exp_q.size()));
            break;
         end
         if (k == rst_at) begin
            rst = 1'b0;
            #1;
            check("rst_push", 32'(push), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_ascii", 32'(ascii), 32'd0);
            @(negedge clk);
            rst = 1'b1;
            return;
         end
         if (k == poke_at) begin
            start = 1'b1;
            humidity = 8'd99;
            temperature = ~t;
         end
         if ((stall_rem > 0) && (k == stall_at)) begin
            f = 1'b1;
            stall_rem--;
         end else if (rand_full && (cyc < 100)) begin
            f = ($urandom_range(3, 0) == 0);
         end else begin
            f = 1'b0;
         end
         full = f;
         #1;
         if (f) begin
            check("stall_push", 32'(push), 32'd0);
            check("stall_ascii", 32'(ascii), 32'd0);
         end else begin
            check("char_push", 32'(push), 32'd1);
            check($sformatf("char_%0d", k), 32'(ascii), 32'(exp_q[k]));
            k++;
         end
      end
      @(negedge clk);
      full = 1'($urandom_range(1, 0));
      #1;
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("done_push", 32'(push), 32'd0);
      @(negedge clk);
      full = 1'b0;
      #1;
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_push", 32'(push), 32'd0);
      check("idle_ascii", 32'(ascii), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      humidity = 8'd0;
      temperature = 8'd0;
      full = 1'b0;
      #12;
      check("reset_push", 32'(push), 32'd0);
      check("reset_ascii", 32'(ascii), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_line(8'd45, 8'd23, -1, 0, -1, -1, 1'b0);
      run_line(8'd255, 8'd0, -1, 0, -1, -1, 1'b0);
      run_line(8'd9, 8'd100, -1, 0, -1, -1, 1'b0);
      run_line(8'd7, 8'd199, 5, 3, -1, -1, 1'b0);
      run_line(8'd62, 8'd38, -1, 0, 3, -1, 1'b0);
      // Idle cycle after a line with start low: nothing must happen.
      @(negedge clk);
      #1;
      check("no_extra_line_busy", 32'(busy), 32'd0);
      check("no_extra_line_push", 32'(push), 32'd0);
      run_line(8'd128, 8'd64, -1, 0, -1, 7, 1'b0);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);
      run_line(8'd33, 8'd77, -1, 0, -1, -1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         run_line(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), -1, 0, -1, -1, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sensor_ascii_sender.md
# sensor_ascii_sender

Formats one humidity/temperature reading into a fixed-layout ASCII line and streams it byte by byte into the UART TX FIFO. It sits directly upstream of the UART/FIFO loopback stage and drives one of its push/ascii input pairs, for example `push_dht11`/`ascii_dht11`. It snapshots both readings on a start pulse, converts each to three decimal digits, and issues one FIFO push per character. It honours FIFO back-pressure, so no character is dropped or duplicated.

## Interface
Parameters:
- `HUM_TAG`, default 8'h48 ('H'): first character of the line.
- `TMP_TAG`, default 8'h54 ('T'): character that introduces the temperature field.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request to send one line; level-sampled, effective only in IDLE.
- `humidity`  in  8  unsigned binary, 0–255.
- `temperature`  in  8  unsigned binary, 0–255.
- `full`  in  1  TX FIFO full flag.
- `push`  out  1  FIFO write strobe; one character is written per clock edge while high.
- `ascii`  out  8  character being pushed; valid only while `push`=1, 8'h00 otherwise.
- `busy`  out  1  high in CONVERT, SEND and DONE.
- `done`  out  1  one-cycle pulse after the last character is written.

## Operation
- FSM states are IDLE, CONVERT, SEND and DONE.
- IDLE → CONVERT on `start`=1. The same edge latches `humidity` and `temperature` into snapshot registers.
- CONVERT → SEND unconditionally. This edge latches 3 BCD digits per value (hundreds, tens, ones) and clears the character index to 0.
- SEND: `push` = ~`full` (combinational) and `ascii` = char[index].
  - The index increments only on edges where `push`=1.
  - The FSM moves to DONE on the edge that writes the last character.
- DONE → IDLE unconditionally. `done`=1 for this single cycle.
- Character sequence with the macro defined is 15 bytes: `HUM_TAG`, '=', H2, H1, H0, '%', ' ', `TMP_TAG`, '=', T2, T1, T0, 'C', 8'h0D, 8'h0A.
- Digits are encoded as 8'h30 + BCD digit. Leading zeros are kept, so 7 → "007".
- A `start` pulse in CONVERT, SEND or DONE is ignored. It is neither queued nor counted.
- `humidity` and `temperature` changes after the snapshot have no effect on the line in progress.
- The index is 4 bits and never wraps mid-line, because it is cleared in CONVERT.

## Timing
- Reset values: state IDLE, `push`=0, `ascii`=8'h00, `busy`=0, `done`=0, snapshots and index 0.
- `start` sampled at edge E0 gives CONVERT after E0 and SEND after E1. The first character is written at E2.
- Without stalls, characters are written on E2..E16. `done` is high between E16 and E17, and IDLE is reached after E17. The earliest next accepted `start` is at E18.
- Each cycle with `full`=1 in SEND adds exactly one cycle of latency. `push` is 0 in that cycle and the index holds.
- `full` is used combinationally, with no registered lag, so a push is never issued into a full FIFO.
- Asserting `rst` during any state returns the block to IDLE at once, with `push`=0. The partial line is abandoned and is not resumed after reset.

## Configuration
- `SENSOR_SENDER_CRLF_EN` defined: the line ends in 8'h0D 8'h0A and is 15 characters long.
- Macro not defined: the line ends in 8'h0A only and is 14 characters long. The last-index compare and the character mux shrink to match; all other timing is unchanged.

## Structure
- Shared package `sensor_ascii_pkg` holds:
  - FSM state typedef;
  - character constants (ASCII_ZERO, ASCII_EQ, ASCII_PCT, ASCII_SP, ASCII_C, ASCII_CR, ASCII_LF);
  - line-length constants for both macro settings.
- Sub-module `bin2bcd8`: combinational 8-bit to 3-digit BCD converter using double-dabble. Two instances are registered in CONVERT.

## Test plan
- humidity=45, temperature=23, `full`=0, `start` pulse → 15 consecutive pushes "H=045% T=023C\r\n" on E2..E16, then `done` for one cycle, `busy` low after E17.
- humidity=255, temperature=0 → "H=255% T=000C\r\n"; humidity=9, temperature=100 → "H=009% T=100C\r\n".
- `full`=1 for 3 cycles while index is 5 → `push`=0 in those cycles, the '%' character is written once after release, and the line ends at E19 with no loss or duplication.
- `start` re-pulsed during SEND, and humidity changed to 99 mid-line → ignored; the line still shows the snapshot value, with exactly one line and one `done`.
- `rst`=0 asserted while index is 7 → `push`=0 and `busy`=0 immediately. After release, a new `start` sends a complete line from `HUM_TAG`.
- `SENSOR_SENDER_CRLF_EN` undefined, humidity=45, temperature=23 → 14 pushes ending in 8'h0A, `done` after E15.
